// File: rtl/button_toggle_bank.sv
// button_toggle_bank: N-channel debounced push-button toggle/momentary controller.
// One shared debounce sample tick feeds an array of identical per-channel slices.
// Optional long-press clear is built when BUTTON_TOGGLE_BANK_LONG_PRESS_EN is defined;
// without it LONG is tied to 0 and no hold counters exist.

// Per-channel slice: synchroniser, debouncer, press detect, state register, hold counter.
module button_toggle_chan #(
    parameter bit TOGGLE         = 1'b1,
    parameter bit ACTIVE_LOW     = 1'b0,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    input  logic clr,
    output logic state,
    output logic press,
    output logic long_hit
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    logic          sync_a, sync_b;
    logic          lvl;
    logic          deb, deb_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          rise;
    logic          long_evt;
    logic          state_nxt;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Polarity fix happens after the synchroniser so the flops see the raw pin.
    assign lvl = ACTIVE_LOW ? ~sync_b : sync_b;

    // Debounce: accept a new level only after DEBOUNCE_TICKS consecutive differing samples.
    always_comb begin
        dcnt_nxt = dcnt;
        deb_nxt  = deb;
        if (tick) begin
            if (lvl == deb) begin
                dcnt_nxt = '0;
            end else if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                deb_nxt  = lvl;
                dcnt_nxt = '0;
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end
    end

    assign rise = ~deb & deb_nxt;

`ifdef BUTTON_TOGGLE_BANK_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    logic [HW-1:0] hcnt;

    // Hold counter: counts held ticks, saturates at LONG_TICKS so the pulse fires once per hold.
    always_ff @(posedge clk) begin
        if (rst || !deb) begin
            hcnt <= '0;
        end else if (tick && hcnt != HW'(LONG_TICKS)) begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign long_evt = tick & deb & (hcnt == HW'(LONG_TICKS - 1));
`else
    assign long_evt = 1'b0;
`endif

    // Next state: clear beats long-press, which beats the press/level update.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = 1'b0;
        end else if (long_evt) begin
            state_nxt = 1'b0;
        end else if (TOGGLE) begin
            if (rise) state_nxt = ~state;
        end else begin
            state_nxt = deb_nxt;
        end
    end

    // Debounce, state and pulse registers; PRESS lands on the same edge as the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb      <= 1'b0;
            dcnt     <= '0;
            state    <= 1'b0;
            press    <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            deb      <= deb_nxt;
            dcnt     <= dcnt_nxt;
            state    <= state_nxt;
            press    <= rise;
            long_hit <= long_evt;
        end
    end
endmodule

module button_toggle_bank #(
    parameter int             N_CH           = 4,
    parameter int             TICK_DIV       = 16000,
    parameter int             DEBOUNCE_TICKS = 10,
    parameter logic [N_CH-1:0] MODE_MASK     = {N_CH{1'b1}},
    parameter bit             ACTIVE_LOW     = 1'b0,
    parameter int             LONG_TICKS     = 1000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    input  logic [N_CH-1:0] CLR,
    output logic [N_CH-1:0] STATE,
    output logic [N_CH-1:0] PRESS,
    output logic [N_CH-1:0] LONG
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    // Shared sample-tick divider; wraps on the same edge the tick is consumed.
    always_ff @(posedge CLK) begin
        if (RST || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_toggle_chan #(
            .TOGGLE         (MODE_MASK[i]),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS)
        ) u_ch (
            .clk      (CLK),
            .rst      (RST),
            .tick     (tick),
            .btn      (BTN[i]),
            .clr      (CLR[i]),
            .state    (STATE[i]),
            .press    (PRESS[i]),
            .long_hit (LONG[i])
        );
    end
endmodule

// File: tb/tb_button_toggle_bank.sv
// Directed bench for button_toggle_bank: N_CH=2, TICK_DIV=4, DEBOUNCE_TICKS=3,
// LONG_TICKS=10, ch0 toggle, ch1 momentary.
module tb_button_toggle_bank;
    logic       CLK;
    logic       RST;
    logic [1:0] BTN, CLR, STATE, PRESS, LONG;

    int n_chk  = 0;
    int n_fail = 0;
    int at, p, l, early, first1, fall, pc, pat, lat, lc;

    button_toggle_bank #(
        .N_CH(2), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .MODE_MASK(2'b01),
        .ACTIVE_LOW(1'b0), .LONG_TICKS(10)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .CLR(CLR),
        .STATE(STATE), .PRESS(PRESS), .LONG(LONG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock, sampled 1 ns after the edge; inputs are also changed here.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n, output int np, output int nl);
        np = 0;
        nl = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            np += $countones(PRESS);
            nl += $countones(LONG);
        end
    endtask

    // Cycles until PRESS[ch]; 0 if the budget expires.
    task automatic wait_press(input int ch, input int budget, output int c_at);
        c_at = 0;
        for (int c = 1; c <= budget; c++) begin
            cyc();
            if (PRESS[ch]) begin
                c_at = c;
                break;
            end
        end
    endtask

    function automatic logic in_win(input int v);
        return (v >= 11 && v <= 14);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; BTN = 2'b11; CLR = 2'b00;

        // 1: reset with buttons held, then full qualification after release
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_state", STATE, 0);
            chk("rst_press", PRESS, 0);
            chk("rst_long",  LONG,  0);
        end
        RST = 1'b0;
        at = 0; early = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (PRESS[0]) begin
                at = c;
                break;
            end
            if (STATE != 0 || LONG != 0) early++;
        end
        chk("t1_quiet_before_press", early, 0);
        chk("t1_press_cycle", at, 12);
        chk("t1_press_both", PRESS, 2'b11);
        chk("t1_state", STATE, 2'b11);
        cyc();
        chk("t1_press_one_cycle", PRESS, 0);
        BTN = 2'b00;
        run(20, p, l);
        chk("t1_release_no_press", p, 0);
        chk("t1_release_state", STATE, 2'b01);

        // 2: toggle on ch0 twice, no pulse on release
        CLR = 2'b01;
        cyc();
        chk("t2_clr_state", STATE, 2'b00);
        CLR = 2'b00;
        BTN = 2'b01;
        wait_press(0, 20, at);
        chk("t2_press1_window", in_win(at), 1);
        chk("t2_state_on", STATE, 2'b01);
        run(20 - at, p, l);
        chk("t2_hold_no_repeat", p, 0);
        BTN = 2'b00;
        run(20, p, l);
        chk("t2_no_release_pulse", p, 0);
        chk("t2_state_kept", STATE, 2'b01);
        BTN = 2'b01;
        wait_press(0, 20, at);
        chk("t2_press2_window", in_win(at), 1);
        chk("t2_state_off", STATE, 2'b00);
        run(4, p, l);
        BTN = 2'b00;
        run(30, p, l);
        chk("t2_release2_no_press", p, 0);

        // 3: two-tick glitch rejected, next press needs full qualification
        BTN = 2'b01;
        run(8, p, l);
        BTN = 2'b00;
        run(30, pc, l);
        chk("t3_glitch_no_press", p + pc, 0);
        chk("t3_glitch_state", STATE, 2'b00);
        BTN = 2'b01;
        wait_press(0, 20, at);
        chk("t3_full_requal", in_win(at), 1);
        chk("t3_state", STATE, 2'b01);
        run(4, p, l);
        BTN = 2'b00;
        run(30, p, l);

        // 4: momentary ch1, clear for one cycle only
        BTN = 2'b10;
        first1 = 0; pc = 0;
        for (int c = 1; c <= 38; c++) begin
            cyc();
            pc += PRESS[1];
            if (STATE[1] && first1 == 0) first1 = c;
        end
        chk("t4_state_rise_window", in_win(first1), 1);
        chk("t4_single_press", pc, 1);
        CLR = 2'b10;
        cyc();
        chk("t4_clr_momentary", STATE[1], 0);
        CLR = 2'b00;
        cyc();
        chk("t4_resume", STATE[1], 1);
        BTN = 2'b00;
        fall = 0; pc = 0;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            pc += PRESS[1];
            if (!STATE[1] && fall == 0) fall = c;
        end
        chk("t4_state_fall_window", in_win(fall), 1);
        chk("t4_no_release_pulse", pc, 0);
        chk("t4_ch0_independent", STATE[0], 1);

        // 5: clear coincident with a press wins the state, press still pulses
        CLR = 2'b01;
        cyc();
        chk("t5_pre_clear", STATE[0], 0);
        BTN = 2'b01;
        wait_press(0, 20, at);
        chk("t5_press_under_clr", in_win(at), 1);
        chk("t5_clr_wins", STATE[0], 0);
        chk("t5_press_pulse", PRESS, 2'b01);
        CLR = 2'b00;
        run(5, p, l);
        chk("t5_state_stays", STATE[0], 0);
        BTN = 2'b00;
        run(30, p, l);

        // 6: long hold on ch0
        BTN = 2'b01;
        pat = 0; lat = 0; lc = 0;
        for (int c = 1; c <= 60; c++) begin
            cyc();
            if (PRESS[0]) pat = c;
            if (LONG != 0) begin
                lc += $countones(LONG);
                lat = c;
            end
        end
        chk("t6_press_window", in_win(pat), 1);
`ifdef BUTTON_TOGGLE_BANK_LONG_PRESS_EN
        chk("t6_long_count", lc, 1);
        chk("t6_long_delay", lat - pat, 40);
        chk("t6_state_cleared", STATE[0], 0);
`else
        chk("t6_long_count", lc, 0);
        chk("t6_state_held", STATE[0], 1);
`endif
        run(20, p, l);
        chk("t6_no_repeat_long", l, 0);
        BTN = 2'b00;
        run(30, p, l);
        chk("t6_release_quiet", p + l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
